// File: rtl/array_pkg.sv
// Shared types and width helpers for the array stream writer family.
//   wr_state_t : writer FSM state (FILL collecting elements, FULL presenting ARR)
//   idx_w(n)   : index width for an n-entry dimension, never below 1 bit
//   cnt_w(r,c) : width of a counter that reaches r*c inclusive
package array_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } wr_state_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned r, input int unsigned c);
        return $clog2(r * c + 1);
    endfunction

endpackage

// File: rtl/array_index_counter.sv
// Row-major row/col pointer pair for the sequential write mode.
//   CLK, RST : clock, asynchronous active-high reset
//   clr      : return both pointers to 0 (array released)
//   en       : advance one position (beat accepted)
//   row, col : current write position
module array_index_counter
    import array_pkg::*;
#(
    parameter int unsigned ROWS = 2,
    parameter int unsigned COLS = 2
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    clr,
    input  logic                    en,
    output logic [idx_w(ROWS)-1:0]  row,
    output logic [idx_w(COLS)-1:0]  col
);

    localparam int unsigned RW = idx_w(ROWS);
    localparam int unsigned CW = idx_w(COLS);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;

    // Wrapping at the very last cell is harmless: the FSM is FULL by then and
    // the release clears the pointers anyway.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            row_q <= '0;
            col_q <= '0;
        end else if (clr) begin
            row_q <= '0;
            col_q <= '0;
        end else if (en) begin
            if (col_q == COL_MAX) begin
                col_q <= '0;
                row_q <= (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    assign row = row_q;
    assign col = col_q;

endmodule

// File: rtl/array_stream_writer.sv
// Collects a stream of WIDTH-bit elements into a ROWS x COLS array and presents
// the completed array with a valid/ready handshake.
//   CLK, RST            : clock, asynchronous active-high reset
//   IN_DATA/VALID/LAST  : element stream; IN_LAST ends the array early
//   IN_READY            : element accepted this cycle (state FILL)
//   ARR                 : assembled array, stable while OUT_VALID
//   OUT_COUNT           : number of elements written into ARR
//   OUT_VALID/OUT_READY : array handshake
// Build option ARRAY_WR_ADDR_EN: random-access mode with IN_ROW/IN_COL
// addressing and a sticky ERR flag for out-of-range addresses; only IN_LAST
// completes an array. Without it, elements fill ARR row-major.
module array_stream_writer
    import array_pkg::*;
#(
    parameter int unsigned ROWS  = 2,
    parameter int unsigned COLS  = 2,
    parameter int unsigned WIDTH = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [WIDTH-1:0]              IN_DATA,
    input  logic                          IN_VALID,
    input  logic                          IN_LAST,
`ifdef ARRAY_WR_ADDR_EN
    input  logic [idx_w(ROWS)-1:0]        IN_ROW,
    input  logic [idx_w(COLS)-1:0]        IN_COL,
    output logic                          ERR,
`endif
    output logic                          IN_READY,
    output logic [WIDTH-1:0]              ARR [ROWS][COLS],
    output logic [cnt_w(ROWS, COLS)-1:0]  OUT_COUNT,
    output logic                          OUT_VALID,
    input  logic                          OUT_READY
);

    localparam int unsigned RW    = idx_w(ROWS);
    localparam int unsigned CW    = idx_w(COLS);
    localparam int unsigned NW    = cnt_w(ROWS, COLS);
    localparam int unsigned TOTAL = ROWS * COLS;
    localparam logic [NW-1:0] COUNT_MAX = NW'(TOTAL);

    wr_state_t         state_q, state_d;
    logic [WIDTH-1:0]  arr_q [ROWS][COLS];
    logic [NW-1:0]     count_q;
    logic              beat;
    logic              release_arr;
    logic              wr_en;
    logic              last_beat;
    logic [RW-1:0]     wr_row;
    logic [CW-1:0]     wr_col;

    assign IN_READY    = (state_q == FILL);
    assign OUT_VALID   = (state_q == FULL);
    assign beat        = IN_VALID & IN_READY;
    assign release_arr = OUT_VALID & OUT_READY;

`ifdef ARRAY_WR_ADDR_EN
    logic addr_ok;
    logic err_q;

    assign addr_ok   = (32'(IN_ROW) < ROWS) && (32'(IN_COL) < COLS);
    assign wr_en     = beat & addr_ok;
    assign wr_row    = IN_ROW;
    assign wr_col    = IN_COL;
    // A dropped beat still honours IN_LAST; only the write and count are skipped.
    assign last_beat = beat & IN_LAST;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if (beat && !addr_ok) begin
            err_q <= 1'b1;
        end
    end

    assign ERR = err_q;
`else
    array_index_counter #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_index_counter (
        .CLK (CLK),
        .RST (RST),
        .clr (release_arr),
        .en  (beat),
        .row (wr_row),
        .col (wr_col)
    );

    assign wr_en     = beat;
    assign last_beat = beat & (IN_LAST | (count_q == COUNT_MAX - 1'b1));
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:    if (last_beat)   state_d = FULL;
            FULL:    if (release_arr) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Clearing on release is what leaves unwritten cells at 0 after an early IN_LAST.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            arr_q   <= '{default: '0};
            count_q <= '0;
        end else if (release_arr) begin
            arr_q   <= '{default: '0};
            count_q <= '0;
        end else if (wr_en) begin
            arr_q[wr_row][wr_col] <= IN_DATA;
            if (count_q != COUNT_MAX) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign ARR       = arr_q;
    assign OUT_COUNT = count_q;

endmodule
